// File: rtl/nand_host_ctrl.sv
// NAND flash host controller: sequences command/address/data strobes for page read,
// program, block erase, read ID, read status and reset. Busy timeout enabled by NAND_TIMEOUT_EN.
module nand_host_ctrl #(
    parameter int T_WP       = 2,
    parameter int T_WH       = 2,
    parameter int T_WB       = 8,
    parameter int TMO_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_row,
    input  logic [15:0] cmd_col,
    input  logic [11:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        CE_n,
    output logic        CLE,
    output logic        ALE,
    output logic        WE_n,
    output logic        RE_n,
    output logic [7:0]  dio_out,
    output logic        dio_oe,
    input  logic [7:0]  dio_in,
    input  logic        R_nB
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD1, S_ADDR, S_WDATA, S_CMD2, S_WAIT_WB, S_WAIT_RDY, S_RDATA, S_DONE
    } state_t;

    localparam logic [2:0] OP_READ = 3'd0, OP_PROG = 3'd1, OP_ERASE = 3'd2,
                           OP_ID   = 3'd3, OP_STAT = 3'd4, OP_RST   = 3'd5;

    // One shared interval timer, wide enough for the longest interval it may time
    localparam int TMR_MAX0 = (T_WP > T_WH) ? T_WP : T_WH;
    localparam int TMR_MAX1 = (TMR_MAX0 > T_WB) ? TMR_MAX0 : T_WB;
    localparam int TMR_MAX  = (TMR_MAX1 > TMO_CYCLES) ? TMR_MAX1 : TMO_CYCLES;
    localparam int TMRW     = $clog2(TMR_MAX + 1);
    localparam logic [TMRW-1:0] WP_LAST = TMRW'(T_WP - 1);
    localparam logic [TMRW-1:0] WH_LAST = TMRW'(T_WH - 1);
    localparam logic [TMRW-1:0] WB_LAST = TMRW'(T_WB - 1);
`ifdef NAND_TIMEOUT_EN
    localparam logic [TMRW-1:0] TMO_LAST = TMRW'(TMO_CYCLES - 1);
`endif

    state_t            state_q, state_d;
    logic              live_q, live_d;
    logic [2:0]        op_q, op_d;
    logic [15:0]       row_q, row_d, col_q, col_d;
    logic [11:0]       len_q, len_d, cnt_q, cnt_d;
    logic [TMRW-1:0]   tmr_q, tmr_d;
    logic              hi_q, hi_d, act_q, act_d, rdy_prev_q, rdy_prev_d, err_q, err_d;
    logic [7:0]        wdat_q, wdat_d, rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [2:0]        n_addr;
    logic [7:0]        cmd1_byte, cmd2_byte, addr_byte;
    logic [11:0]       rd_target;
    logic              run_strobe, strobe_end;

    always_comb begin
        n_addr    = 3'd0;
        cmd1_byte = 8'h00;
        cmd2_byte = 8'h00;
        rd_target = 12'd0;
        addr_byte = 8'h00;
        case (op_q)
            OP_READ:  begin n_addr = 3'd4; cmd1_byte = 8'h00; cmd2_byte = 8'h30; rd_target = len_q; end
            OP_PROG:  begin n_addr = 3'd4; cmd1_byte = 8'h80; cmd2_byte = 8'h10; end
            OP_ERASE: begin n_addr = 3'd2; cmd1_byte = 8'h60; cmd2_byte = 8'hD0; end
            OP_ID:    begin n_addr = 3'd1; cmd1_byte = 8'h90; rd_target = 12'd4; end
            OP_STAT:  begin cmd1_byte = 8'h70; rd_target = 12'd1; end
            OP_RST:   cmd1_byte = 8'hFF;
            default:  ;
        endcase
        if (op_q == OP_ERASE) begin
            addr_byte = cnt_q[0] ? row_q[15:8] : row_q[7:0];
        end else if (op_q != OP_ID) begin
            case (cnt_q[1:0])
                2'd0:    addr_byte = col_q[7:0];
                2'd1:    addr_byte = col_q[15:8];
                2'd2:    addr_byte = row_q[7:0];
                default: addr_byte = row_q[15:8];
            endcase
        end
    end

    assign strobe_end = hi_q && (tmr_q == WH_LAST);

    always_comb begin
        state_d    = state_q;
        live_d     = 1'b1;
        op_d       = op_q;
        row_d      = row_q;
        col_d      = col_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        hi_d       = hi_q;
        act_d      = act_q;
        wdat_d     = wdat_q;
        rdy_prev_d = rdy_prev_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        run_strobe = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        CLE        = 1'b0;
        ALE        = 1'b0;
        WE_n       = 1'b1;
        RE_n       = 1'b1;
        dio_oe     = 1'b0;
        dio_out    = 8'h00;

        case (state_q)
            S_IDLE: begin
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    op_d  = cmd_op;
                    row_d = cmd_row;
                    col_d = cmd_col;
                    len_d = cmd_len;
                    cnt_d = 12'd0;
                    tmr_d = '0;
                    hi_d  = 1'b0;
                    act_d = 1'b0;
                    err_d = (cmd_op > OP_RST);
                    state_d = (cmd_op > OP_RST) ? S_DONE : S_CMD1;
                end
            end
            S_CMD1: begin
                CLE = 1'b1; dio_oe = 1'b1; dio_out = cmd1_byte; WE_n = hi_q; run_strobe = 1'b1;
                if (strobe_end) begin
                    if (n_addr != 3'd0)      state_d = S_ADDR;
                    else if (op_q == OP_STAT) state_d = S_RDATA;
                    else                     state_d = S_WAIT_WB;
                end
            end
            S_ADDR: begin
                ALE = 1'b1; dio_oe = 1'b1; dio_out = addr_byte; WE_n = hi_q; run_strobe = 1'b1;
                if (strobe_end) begin
                    if (cnt_q == {9'd0, n_addr - 3'd1}) begin
                        cnt_d = 12'd0;
                        if (op_q == OP_ID)                         state_d = S_RDATA;
                        else if (op_q == OP_PROG && len_q != 12'd0) state_d = S_WDATA;
                        else                                       state_d = S_CMD2;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
            end
            S_WDATA: begin
                // A byte is taken first, then strobed out; no byte means WE_n stays high
                if (!act_q) begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        wdat_d = wr_data;
                        act_d  = 1'b1;
                    end
                end else begin
                    dio_oe = 1'b1; dio_out = wdat_q; WE_n = hi_q; run_strobe = 1'b1;
                    if (strobe_end) begin
                        act_d = 1'b0;
                        if (cnt_q + 12'd1 == len_q) begin
                            cnt_d   = 12'd0;
                            state_d = S_CMD2;
                        end else begin
                            cnt_d = cnt_q + 12'd1;
                        end
                    end
                end
            end
            S_CMD2: begin
                CLE = 1'b1; dio_oe = 1'b1; dio_out = cmd2_byte; WE_n = hi_q; run_strobe = 1'b1;
                if (strobe_end) state_d = S_WAIT_WB;
            end
            S_WAIT_WB: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == WB_LAST) begin
                    tmr_d      = '0;
                    rdy_prev_d = 1'b0;
                    state_d    = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                rdy_prev_d = R_nB;
                if (R_nB && rdy_prev_q) begin
                    tmr_d   = '0;
                    state_d = (op_q == OP_READ && len_q != 12'd0) ? S_RDATA : S_DONE;
                end
`ifdef NAND_TIMEOUT_EN
                else if (tmr_q == TMO_LAST) begin
                    tmr_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            S_RDATA: begin
                RE_n = hi_q; run_strobe = 1'b1;
                if (!hi_q && tmr_q == WP_LAST) begin
                    rd_data_d  = dio_in;
                    rd_valid_d = 1'b1;
                end
                if (strobe_end) begin
                    if (cnt_q + 12'd1 == rd_target) begin
                        cnt_d   = 12'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobe timing: T_WP cycles active-low, then T_WH cycles high
        if (run_strobe) begin
            if (!hi_q) begin
                if (tmr_q == WP_LAST) begin
                    hi_d  = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end else if (strobe_end) begin
                hi_d  = 1'b0;
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    // Error completions release the chip so an illegal op shows no pin activity
    assign CE_n     = (state_q == S_IDLE) || (state_q == S_DONE && err_q);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            live_q     <= 1'b0;
            op_q       <= 3'd0;
            row_q      <= 16'd0;
            col_q      <= 16'd0;
            len_q      <= 12'd0;
            cnt_q      <= 12'd0;
            tmr_q      <= '0;
            hi_q       <= 1'b0;
            act_q      <= 1'b0;
            wdat_q     <= 8'h00;
            rdy_prev_q <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            op_q       <= op_d;
            row_q      <= row_d;
            col_q      <= col_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            hi_q       <= hi_d;
            act_q      <= act_d;
            wdat_q     <= wdat_d;
            rdy_prev_q <= rdy_prev_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: doc/nand_host_ctrl.md
NAND_HOST_CTRL -- requirements
Module: nand_host_ctrl

Interface
REQ-001 Parameter T_WP, default 2: WE_n/RE_n low-pulse width, clk cycles (>=1).
REQ-002 Parameter T_WH, default 2: WE_n/RE_n high time between pulses, clk cycles (>=1).
REQ-003 Parameter T_WB, default 8: cycles from last command-strobe rising edge to first R_nB sample.
REQ-004 Parameter TMO_CYCLES, default 4096: busy-wait limit; used only with NAND_TIMEOUT_EN.
REQ-005 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  operation request handshake; accepted when both high.
REQ-009 cmd_op  in  3  0 READ_PAGE, 1 PROGRAM_PAGE, 2 ERASE_BLOCK, 3 READ_ID, 4 READ_STATUS, 5 RESET; 6-7 illegal.
REQ-010 cmd_row, cmd_col  in  16 each  page row address {block,page}; byte column address.
REQ-011 cmd_len  in  12  data-phase byte count; 0 = no data phase.
REQ-012 wr_data/wr_valid/wr_ready  in/in/out  8/1/1  program data stream, byte moves when wr_valid&&wr_ready.
REQ-013 rd_data/rd_valid  out  8/1  read byte with one-cycle valid strobe; no backpressure.
REQ-014 done, err  out  1 each  one-cycle completion pulse; err high with done on illegal op or timeout.
REQ-015 CE_n, CLE, ALE, WE_n, RE_n  out  1 each  NAND control pins.
REQ-016 dio_out/dio_oe/dio_in  out/out/in  8/1/8  DIO bus split; top level builds tristate.
REQ-017 R_nB  in  1  device ready(1)/busy(0).

Function
REQ-018 States: IDLE, CMD1, ADDR, WDATA, CMD2, WAIT_WB, WAIT_RDY, RDATA, DONE.
REQ-019 cmd_ready high only in IDLE; CE_n low from CMD1 through DONE, high in IDLE.
REQ-020 Each write strobe: dio_out/CLE/ALE stable, dio_oe=1, WE_n low T_WP cycles then high T_WH cycles; values held until strobe ends.
REQ-021 Command strobe: CLE=1, ALE=0; address strobe: ALE=1, CLE=0; data strobe: both 0.
REQ-022 READ_PAGE: 00, addr col[7:0],col[15:8],row[7:0],row[15:8], 30, WAIT_WB, WAIT_RDY, RDATA cmd_len bytes.
REQ-023 PROGRAM_PAGE: 80, same 4 address bytes, WDATA cmd_len bytes, 10, WAIT_WB, WAIT_RDY.
REQ-024 ERASE_BLOCK: 60, addr row[7:0],row[15:8], D0, WAIT_WB, WAIT_RDY; cmd_len ignored.
REQ-025 READ_ID: 90, addr 00, RDATA exactly 4 bytes; READ_STATUS: 70, RDATA exactly 1 byte; RESET: FF, WAIT_WB, WAIT_RDY.
REQ-026 Read strobe: dio_oe=0, RE_n low T_RP=T_WP cycles; dio_in sampled on final low cycle; rd_valid pulses that cycle; RE_n high T_WH.
REQ-027 WDATA: wr_ready high one cycle at strobe start; if wr_valid low, WE_n stays high and FSM waits (stall, no timeout).
REQ-028 WAIT_WB counts T_WB cycles ignoring R_nB; WAIT_RDY exits when R_nB sampled 1 on two consecutive cycles.
REQ-029 Byte counter 12 bits, counts up to cmd_len then leaves data phase; cmd_len=0 skips WDATA/RDATA.
REQ-030 DONE lasts one cycle: done=1, then IDLE; back-to-back commands allowed from next cycle.
REQ-031 Illegal cmd_op: accepted, no pin activity, done=err=1 one cycle after acceptance.
REQ-032 cmd_* inputs captured at acceptance; later changes ignored until next acceptance.

Reset
REQ-033 rst_n low at any time, including mid-strobe: immediately CE_n=WE_n=RE_n=1, CLE=ALE=0, dio_oe=0, dio_out=0, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, done=err=0, counters 0, state IDLE.
REQ-034 cmd_ready rises the first clk edge after rst_n deasserts.

Configuration
REQ-035 Macro NAND_TIMEOUT_EN defined: WAIT_RDY counting TMO_CYCLES without ready -> DONE with err=1, CE_n released.
REQ-036 NAND_TIMEOUT_EN undefined: WAIT_RDY waits indefinitely, err only for illegal op; no timeout counter present.

Verification
REQ-037 READ_ID after reset, model returns EC,A1,00,15 -> pins 90 then ALE byte 00, rd_data EC,A1,00,15 in order, done=1 err=0.
REQ-038 PROGRAM_PAGE row=0x0040 col=0x0000 len=4 data 11,22,33,44 -> strobes 80,00,00,40,00,11,22,33,44,10; done after R_nB returns high.
REQ-039 READ_PAGE row=0x0040 col=0 len=4 after REQ-038 -> 00,00,00,40,00,30 then rd_data 11,22,33,44.
REQ-040 ERASE_BLOCK row=0x0080 -> 60,80,00,D0; no RE_n activity; wr_valid held low 10 cycles in program stalls WE_n high.
REQ-041 NAND_TIMEOUT_EN, TMO_CYCLES=16, R_nB stuck 0 -> done=err=1 after 16 WAIT_RDY cycles; cmd_op=7 -> done=err=1, no strobes.
REQ-042 rst_n pulsed low during WE_n low of PROGRAM data byte -> all pins idle same cycle; next READ_STATUS completes normally.
